// File: rtl/dist_pkg.sv
// Shared types and constants for the distance calculator: FSM state encoding,
// result widths and the saturating accumulate helper.
package dist_pkg;

  typedef enum logic [1:0] {
    LOAD_Q = 2'd0,
    RUN    = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam int unsigned DIST_W = 32;
  localparam int unsigned IDX_W  = 32;

  localparam logic [DIST_W-1:0] DIST_SAT = {DIST_W{1'b1}};

  // Add with clamp at DIST_SAT; once the sum reaches DIST_SAT it stays there
  // because every term is non-negative.
  function automatic logic [DIST_W-1:0] sat_add(input logic [DIST_W-1:0] acc,
                                                input logic [DIST_W-1:0] term);
    logic [DIST_W:0] sum;
    sum = {1'b0, acc} + {1'b0, term};
    return sum[DIST_W] ? DIST_SAT : sum[DIST_W-1:0];
  endfunction

endpackage

// File: rtl/dist_term.sv
// Per-element distance term: squared absolute difference by default, or plain
// absolute difference (L1) when DIST_CALC_L1_EN is defined.
module dist_term #(
  parameter int unsigned DATA_W = 16
) (
  input  logic [DATA_W-1:0]   i_a,
  input  logic [DATA_W-1:0]   i_b,
  output logic [2*DATA_W-1:0] o_term
);

  logic [DATA_W-1:0]   w_diff;
  logic [2*DATA_W-1:0] w_diff_ext;

  always_comb begin
    w_diff = (i_a > i_b) ? (i_a - i_b) : (i_b - i_a);
  end

  assign w_diff_ext = {{DATA_W{1'b0}}, w_diff};

`ifdef DIST_CALC_L1_EN
  assign o_term = w_diff_ext;
`else
  assign o_term = w_diff_ext * w_diff_ext;
`endif

endmodule

// File: rtl/dist_calc.sv
// Streaming query-to-sample distance calculator with a held result handshake.
// Define DIST_CALC_L1_EN for Manhattan distance instead of squared Euclidean.
module dist_calc
  import dist_pkg::*;
#(
  parameter int unsigned DIM    = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              q_valid,
  input  logic [DATA_W-1:0] q_data,
  input  logic              q_clear,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DIST_W-1:0] out_dist,
  output logic [IDX_W-1:0]  out_index,
  output logic              busy
);

  localparam int unsigned CNT_W  = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int unsigned TERM_W = 2 * DATA_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIM - 1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_q [DIM];
  logic [DIST_W-1:0]   r_acc;
  logic [IDX_W-1:0]    r_smp;
  logic                r_out_valid;
  logic [DIST_W-1:0]   r_out_dist;
  logic [IDX_W-1:0]    r_out_index;

  logic [DATA_W-1:0]   w_q_sel;
  logic [TERM_W-1:0]   w_term;
  logic [DIST_W-1:0]   w_term_dist;
  logic [DIST_W-1:0]   w_acc_next;
  logic                w_last;

  assign w_q_sel = r_q[r_cnt];
  assign w_last  = (r_cnt == LAST);

  dist_term #(
    .DATA_W (DATA_W)
  ) u_term (
    .i_a    (s_data),
    .i_b    (w_q_sel),
    .o_term (w_term)
  );

  // Terms wider than the result are clamped so the saturation stays exact.
  if (TERM_W > DIST_W) begin : g_term_clamp
    assign w_term_dist = (|w_term[TERM_W-1:DIST_W]) ? DIST_SAT : w_term[DIST_W-1:0];
  end else begin : g_term_ext
    assign w_term_dist = DIST_W'(w_term);
  end

  assign w_acc_next = sat_add(r_acc, w_term_dist);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= LOAD_Q;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_smp       <= '0;
      r_out_valid <= 1'b0;
      r_out_dist  <= '0;
      r_out_index <= '0;
      for (int i = 0; i < int'(DIM); i++) begin
        r_q[i] <= '0;
      end
    end else if (q_clear) begin
      // Clear wins over everything, including a same-cycle out_ready.
      r_state     <= LOAD_Q;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_smp       <= '0;
      r_out_valid <= 1'b0;
      for (int i = 0; i < int'(DIM); i++) begin
        r_q[i] <= '0;
      end
    end else begin
      unique case (r_state)
        LOAD_Q: begin
          if (q_valid) begin
            r_q[r_cnt] <= q_data;
            if (w_last) begin
              r_cnt   <= '0;
              r_smp   <= '0;
              r_state <= RUN;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        RUN: begin
          if (s_valid) begin
            if (w_last) begin
              r_out_dist  <= w_acc_next;
              r_out_index <= r_smp;
              r_out_valid <= 1'b1;
              r_acc       <= '0;
              r_cnt       <= '0;
              r_smp       <= r_smp + IDX_W'(1);
              r_state     <= HOLD;
            end else begin
              r_acc <= w_acc_next;
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= RUN;
          end
        end
        default: begin
          r_state <= LOAD_Q;
        end
      endcase
    end
  end

  assign s_ready   = (r_state == RUN);
  assign busy      = (r_state != LOAD_Q);
  assign out_valid = r_out_valid;
  assign out_dist  = r_out_dist;
  assign out_index = r_out_index;

endmodule

// File: tb/tb_dist_calc.sv
// Self-checking bench for dist_calc (DIM=4, DATA_W=16): a vector-level reference
// model checked every cycle, plus hand-computed literal expectations.
module tb_dist_calc;

  localparam int unsigned DIM = 4;
  localparam int unsigned DW  = 16;

`ifdef DIST_CALC_L1_EN
  localparam logic [31:0] E_ZERO = 32'd10;
  localparam logic [31:0] E_SAT  = 32'h0003_FFFC;
  localparam logic [31:0] E_REV  = 32'd8;
`else
  localparam logic [31:0] E_ZERO = 32'd30;
  localparam logic [31:0] E_SAT  = 32'hFFFF_FFFF;
  localparam logic [31:0] E_REV  = 32'd20;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          q_valid = 1'b0;
  logic [DW-1:0] q_data = '0;
  logic          q_clear = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_dist;
  logic [31:0]   out_index;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  dist_calc #(
    .DIM    (DIM),
    .DATA_W (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .q_valid   (q_valid),
    .q_data    (q_data),
    .q_clear   (q_clear),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dist  (out_dist),
    .out_index (out_index),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: phase 0=loading query, 1=streaming samples, 2=holding result.
  int unsigned   m_phase;
  int unsigned   m_cnt;
  int unsigned   m_smp;
  logic [DW-1:0] m_q [DIM];
  logic [DW-1:0] m_s [DIM];
  logic          m_valid;
  logic [31:0]   m_dist;
  logic [31:0]   m_idx;

  // Whole-vector distance from the query and the collected sample elements.
  function automatic logic [31:0] ref_dist(input logic [DW-1:0] last);
    longint unsigned sum = 0;
    longint unsigned d;
    logic [DW-1:0]   s;
    for (int i = 0; i < int'(DIM); i++) begin
      s = (i == int'(DIM) - 1) ? last : m_s[i];
      d = (m_q[i] > s) ? (64'(m_q[i]) - 64'(s)) : (64'(s) - 64'(m_q[i]));
`ifdef DIST_CALC_L1_EN
      sum += d;
`else
      sum += d * d;
`endif
    end
    if (sum > 64'hFFFF_FFFF) return 32'hFFFF_FFFF;
    return 32'(sum);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase <= 0;
      m_cnt   <= 0;
      m_smp   <= 0;
      m_valid <= 1'b0;
      m_dist  <= '0;
      m_idx   <= '0;
      for (int i = 0; i < int'(DIM); i++) m_q[i] <= '0;
    end else if (q_clear) begin
      m_phase <= 0;
      m_cnt   <= 0;
      m_smp   <= 0;
      m_valid <= 1'b0;
    end else if (m_phase == 0) begin
      if (q_valid) begin
        m_q[m_cnt] <= q_data;
        if (m_cnt == DIM - 1) begin
          m_cnt   <= 0;
          m_smp   <= 0;
          m_phase <= 1;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end else if (m_phase == 1) begin
      if (s_valid) begin
        m_s[m_cnt] <= s_data;
        if (m_cnt == DIM - 1) begin
          m_dist  <= ref_dist(s_data);
          m_idx   <= m_smp;
          m_valid <= 1'b1;
          m_smp   <= m_smp + 1;
          m_cnt   <= 0;
          m_phase <= 2;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end else if (out_ready) begin
      m_valid <= 1'b0;
      m_phase <= 1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("cyc_out_valid", 32'(out_valid), 32'(m_valid));
      chk("cyc_s_ready", 32'(s_ready), 32'(m_phase == 1));
      chk("cyc_busy", 32'(busy), 32'(m_phase != 0));
      if (m_valid) begin
        chk("cyc_out_dist", out_dist, m_dist);
        chk("cyc_out_index", out_index, m_idx);
      end
    end
  end

  task automatic load_q(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] c, input logic [DW-1:0] d);
    logic [DW-1:0] v [4];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      q_valid = 1'b1;
      q_data  = v[i];
    end
    @(negedge clk);
    q_valid = 1'b0;
  endtask

  // Streams one vector; the check lands one cycle after the last handshake.
  task automatic send_s(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] c, input logic [DW-1:0] d);
    logic [DW-1:0] v [4];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = v[i];
    end
    @(negedge clk);
    s_valid = 1'b0;
    chk("latency_out_valid", 32'(out_valid), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_dist", out_dist, 32'd0);
    chk("rst_out_index", out_index, 32'd0);
    rst = 1'b1;

    // Identical vectors give zero distance at index 0.
    load_q(16'd1, 16'd2, 16'd3, 16'd4);
    send_s(16'd1, 16'd2, 16'd3, 16'd4);
    chk("t1_dist", out_dist, 32'd0);
    chk("t1_index", out_index, 32'd0);
    chk("t1_model", m_dist, 32'd0);

    // Second vector held while downstream stalls; stray samples ignored.
    @(negedge clk);
    out_ready = 1'b0;
    send_s(16'd0, 16'd0, 16'd0, 16'd0);
    chk("t2_dist", out_dist, E_ZERO);
    chk("t2_index", out_index, 32'd1);
    chk("t2_model", m_dist, E_ZERO);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 16'd7;
      chk("t2_hold_valid", 32'(out_valid), 32'd1);
      chk("t2_hold_dist", out_dist, E_ZERO);
      chk("t2_hold_s_ready", 32'(s_ready), 32'd0);
    end
    s_valid   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t2_release_valid", 32'(out_valid), 32'd0);

    // Clear after two elements, with out_ready also high.
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 16'd9;
    @(negedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    q_clear = 1'b1;
    @(negedge clk);
    q_clear = 1'b0;
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_out_valid", 32'(out_valid), 32'd0);

    // Saturation on maximal differences.
    load_q(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    send_s(16'd0, 16'd0, 16'd0, 16'd0);
    chk("t4_sat_dist", out_dist, E_SAT);
    chk("t4_sat_index", out_index, 32'd0);

    // Saturation does not leak into the next vector; q_valid ignored in RUN.
    q_valid = 1'b1;
    q_data  = 16'd5;
    send_s(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE);
    chk("t5_dist", out_dist, 32'd1);
    chk("t5_index", out_index, 32'd1);
    q_valid = 1'b0;

    // Clear and reload restarts the sample index.
    q_clear = 1'b1;
    @(negedge clk);
    q_clear = 1'b0;
    load_q(16'd1, 16'd2, 16'd3, 16'd4);
    out_ready = 1'b0;
    send_s(16'd4, 16'd3, 16'd2, 16'd1);
    chk("t6_dist", out_dist, E_REV);
    chk("t6_index", out_index, 32'd0);

    // Reset while holding a result drops it immediately.
    #2 rst = 1'b0;
    #1;
    chk("t7_rst_out_valid", 32'(out_valid), 32'd0);
    chk("t7_rst_s_ready", 32'(s_ready), 32'd0);
    chk("t7_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst       = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 16'd3;
    end
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    chk("t7_no_output", 32'(out_valid), 32'd0);
    chk("t7_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dist_calc.md
DIST_CALC -- requirements
Module: dist_calc

Interface
REQ-001 Parameter DIM, default 8, feature elements per vector.
REQ-002 Parameter DATA_W, default 16, unsigned feature element width.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 q_valid  input  1  query element strobe, accepted only in LOAD_Q.
REQ-006 q_data  input  DATA_W  query element, loaded in order 0..DIM-1.
REQ-007 q_clear  input  1  discard query and any partial work, return to LOAD_Q.
REQ-008 s_valid  input  1  sample element valid.
REQ-009 s_data  input  DATA_W  sample element, streamed in order 0..DIM-1.
REQ-010 s_ready  output  1  sample element accepted when s_valid&&s_ready.
REQ-011 out_valid  output  1  distance result valid; feeds top-K sorter input.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 out_dist  output  32  distance of completed sample vector.
REQ-014 out_index  output  32  ordinal of that sample vector since last query load.
REQ-015 busy  output  1  high when state is not LOAD_Q.

Function
REQ-016 FSM states SHALL be LOAD_Q, RUN, HOLD; reset state LOAD_Q.
REQ-017 LOAD_Q: s_ready=0; each q_valid stores q_data at element counter, counter++; on DIM-th element -> RUN, counter=0.
REQ-018 RUN: s_ready=1; each accepted element adds term(s_data, q[cnt]) to accumulator, cnt++.
REQ-019 Term SHALL be (|s_data-q|)^2, absolute difference DATA_W bits, square 2*DATA_W bits, zero-extended to 33-bit add.
REQ-020 Accumulator SHALL saturate at 0xFFFFFFFF; saturation is sticky until vector completes.
REQ-021 On DIM-th accepted element: out_dist=final sum (incl. that term), out_index=sample counter, out_valid=1 next cycle, accumulator and cnt cleared, sample counter++, -> HOLD.
REQ-022 HOLD: s_ready=0; out_dist/out_index stable; on out_ready high -> out_valid=0 next cycle, -> RUN.
REQ-023 Latency: out_valid asserted exactly one cycle after last element handshake; throughput DIM+1 cycles/vector minimum.
REQ-024 Sample counter SHALL wrap 0xFFFFFFFF -> 0 without error.
REQ-025 q_clear SHALL take priority over all inputs in any state: next cycle LOAD_Q, out_valid=0, all counters and accumulator 0; simultaneous out_ready is ignored (result dropped).
REQ-026 q_valid outside LOAD_Q and s_valid outside RUN SHALL be ignored.
REQ-027 DIM=1 SHALL be supported (every accepted element completes a vector).

Reset
REQ-028 rst low SHALL immediately force LOAD_Q; out_valid=0, s_ready=0, busy=0, out_dist=0, out_index=0, counters, accumulator, query registers 0.
REQ-029 Reset mid-vector or mid-HOLD SHALL lose the partial/held result; no output after release until query reloaded.

Configuration
REQ-030 Macro DIST_CALC_L1_EN defined: term = |s_data-q| (Manhattan, L1); undefined: squared difference per REQ-019; all other behaviour identical.

Structure
REQ-031 Shared package dist_pkg SHALL hold FSM state typedef, DIST_W=32, IDX_W=32, saturation constant.
REQ-032 One sub-module dist_term SHALL compute the per-element term combinationally (abs diff, square or L1 per macro).

Verification
REQ-033 DIM=4, query {1,2,3,4}, sample {1,2,3,4}, out_ready=1 -> out_dist=0, out_index=0, one cycle after 4th element.
REQ-034 Next sample {0,0,0,0} -> out_dist=30, out_index=1; with out_ready=0 for 5 cycles result holds stable, s_ready=0 throughout.
REQ-035 DATA_W=16, query all 0xFFFF, sample all 0 -> out_dist=0xFFFFFFFF (saturated).
REQ-036 q_clear after 2 of 4 elements -> no out_valid, busy=0 next cycle; reload query, next result has out_index=0.
REQ-037 DIST_CALC_L1_EN defined, query {1,2,3,4}, sample {0,0,0,0} -> out_dist=10.
REQ-038 rst asserted during HOLD -> out_valid drops immediately, s_ready=0, state LOAD_Q.
